// File: rtl/ldvio_valid_table.sv
// Multi-port valid-bit table with combinational reads, prioritised writes,
// wrap-around range clear and a registered nonzero-entry count.
// Optional macro LDVIO_VALID_BYPASS_EN forwards this cycle's update to reads.
module ldvio_valid_table #(
    parameter int DEPTH    = 16,
    parameter int INDEX    = 4,
    parameter int WIDTH    = 1,
    parameter int RD_PORTS = 4,
    parameter int WR_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RD_PORTS*INDEX-1:0] rd_addr_i,
    output logic [RD_PORTS*WIDTH-1:0] rd_data_o,
    input  logic [WR_PORTS-1:0]       wr_en_i,
    input  logic [WR_PORTS*INDEX-1:0] wr_addr_i,
    input  logic [WR_PORTS*WIDTH-1:0] wr_data_i,
    input  logic                      clr_en_i,
    input  logic [INDEX-1:0]          clr_start_i,
    input  logic [INDEX-1:0]          clr_end_i,
    output logic [INDEX:0]            count_o
);

    logic [WIDTH-1:0] r_entry [DEPTH];
    logic [WIDTH-1:0] w_next  [DEPTH];
    logic [DEPTH-1:0] w_clr;
    logic [INDEX:0]   r_count;
    logic [INDEX:0]   w_count;
    logic             w_no_wrap;

    assign w_no_wrap = (clr_start_i <= clr_end_i);

    // start > end selects the wrapped range start..DEPTH-1 plus 0..end
    for (genvar g = 0; g < DEPTH; g++) begin : g_clr
        assign w_clr[g] = clr_en_i &&
            (w_no_wrap ? (INDEX'(g) >= clr_start_i && INDEX'(g) <= clr_end_i)
                       : (INDEX'(g) >= clr_start_i || INDEX'(g) <= clr_end_i));
    end

    // Clear first, then writes in ascending port order so the highest port wins
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_next[i] = w_clr[i] ? '0 : r_entry[i];
        end
        for (int unsigned p = 0; p < WR_PORTS; p++) begin
            if (wr_en_i[p]) begin
                w_next[wr_addr_i[p*INDEX +: INDEX]] = wr_data_i[p*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_count = w_count + {{INDEX{1'b0}}, |w_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_next[i];
            end
            r_count <= w_count;
        end
    end

    assign count_o = r_count;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
`ifdef LDVIO_VALID_BYPASS_EN
        assign rd_data_o[p*WIDTH +: WIDTH] =
            reset ? '0 : w_next[rd_addr_i[p*INDEX +: INDEX]];
`else
        assign rd_data_o[p*WIDTH +: WIDTH] = r_entry[rd_addr_i[p*INDEX +: INDEX]];
`endif
    end

endmodule

// File: tb/tb_ldvio_valid_table.sv
// Scoreboard bench for ldvio_valid_table: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ldvio_valid_table;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rd_addr_i;
    logic [3:0]  rd_data_o;
    logic [1:0]  wr_en_i;
    logic [7:0]  wr_addr_i;
    logic [1:0]  wr_data_i;
    logic        clr_en_i;
    logic [3:0]  clr_start_i;
    logic [3:0]  clr_end_i;
    logic [4:0]  count_o;

`ifdef LDVIO_VALID_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    ldvio_valid_table #(.DEPTH(16), .INDEX(4), .WIDTH(1), .RD_PORTS(4), .WR_PORTS(2)) dut (
        .clk(clk), .reset(reset), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .clr_en_i(clr_en_i), .clr_start_i(clr_start_i), .clr_end_i(clr_end_i),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    kind;   // 0 = count_o, 1 = read port
        int    port;
        int    exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t e;
    int   act;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            act = (e.kind == 0) ? int'(count_o) : int'(rd_data_o[e.port]);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en_i  = '0;
        wr_addr_i = '0;
        wr_data_i = '0;
        clr_en_i = 1'b0;
        clr_start_i = '0;
        clr_end_i = '0;
    endtask

    task automatic wr(input int p, input int addr, input int data);
        wr_en_i[p] = 1'b1;
        wr_addr_i[p*4 +: 4] = 4'(addr);
        wr_data_i[p] = data[0];
    endtask

    task automatic clr(input int s, input int en);
        clr_en_i = 1'b1;
        clr_start_i = 4'(s);
        clr_end_i = 4'(en);
    endtask

    task automatic chk_rd(input int p, input int addr, input int expv, input string name);
        exp_t x;
        rd_addr_i[p*4 +: 4] = 4'(addr);
        x.name = name; x.kind = 1; x.port = p; x.exp = expv;
        q.push_back(x);
    endtask

    task automatic chk_cnt(input int expv, input string name);
        exp_t x;
        x.name = name; x.kind = 0; x.port = 0; x.exp = expv;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_addr_i = '0;
        idle();
        // Reset held two edges while writes and a clear are requested
        reset = 1'b1;
        wr(0, 3, 1); wr(1, 4, 1); clr(0, 15);
        step(); step();
        reset = 1'b0; idle();
        chk_rd(0, 0, 0, "rst_rd0"); chk_rd(1, 3, 0, "rst_rd3");
        chk_rd(2, 4, 0, "rst_rd4"); chk_rd(3, 5, 0, "rst_rd5");
        chk_cnt(0, "rst_cnt");
        step();

        // Conflict: port1 (data 0) beats port0 (data 1)
        idle(); wr(0, 5, 1); wr(1, 5, 0);
        chk_rd(0, 5, 0, "conf_rdw");
        step();
        idle();
        chk_rd(0, 5, 0, "conf_e5"); chk_cnt(0, "conf_cnt");
        step();

        // Reverse conflict: port1 (data 1) wins
        idle(); wr(0, 5, 0); wr(1, 5, 1);
        chk_rd(1, 5, BYP, "conf2_rdw");
        step();
        idle();
        chk_rd(1, 5, 1, "conf2_e5"); chk_cnt(1, "conf2_cnt");
        step();

        // Read-during-write of addr 7
        idle(); wr(0, 7, 1);
        chk_rd(0, 7, BYP, "bypass_rd7");
        step();
        idle();
        chk_rd(0, 7, 1, "after_wr7"); chk_cnt(2, "cnt_2");
        step();

        // Fill the table two entries per cycle
        for (int i = 0; i < 8; i++) begin
            idle(); wr(0, 2*i, 1); wr(1, 2*i+1, 1);
            step();
        end
        idle();
        chk_rd(0, 0, 1, "fill_e0"); chk_rd(1, 6, 1, "fill_e6");
        chk_rd(2, 15, 1, "fill_e15"); chk_rd(3, 9, 1, "fill_e9");
        chk_cnt(16, "fill_cnt");
        step();
        idle(); wr(0, 2, 1); wr(1, 3, 1);
        step();
        idle();
        chk_cnt(16, "full_nowrap");
        step();

        // Wrapped clear 14..1
        idle(); clr(14, 1);
        step();
        idle();
        chk_rd(0, 14, 0, "wrap_e14"); chk_rd(1, 15, 0, "wrap_e15");
        chk_rd(2, 0, 0, "wrap_e0"); chk_rd(3, 1, 0, "wrap_e1");
        chk_cnt(12, "wrap_cnt");
        step();
        chk_rd(0, 2, 1, "wrap_e2"); chk_rd(1, 13, 1, "wrap_e13");
        step();

        // Refill and clear a single entry
        idle(); wr(0, 14, 1); wr(1, 15, 1);
        step();
        idle(); wr(0, 0, 1); wr(1, 1, 1);
        step();
        idle();
        chk_cnt(16, "refill_cnt");
        clr(9, 9);
        step();
        idle();
        chk_rd(0, 9, 0, "one_e9"); chk_rd(1, 8, 1, "one_e8");
        chk_rd(2, 10, 1, "one_e10"); chk_cnt(15, "one_cnt");
        step();

        // Full clear with a concurrent write to entry 3
        idle(); clr(0, 15); wr(0, 3, 1);
        chk_rd(0, 3, 1, "wbc_rdw3"); chk_rd(1, 4, 1 - BYP, "wbc_rdw4");
        step();
        idle();
        chk_rd(0, 3, 1, "wbc_e3"); chk_rd(1, 2, 0, "wbc_e2");
        chk_rd(2, 4, 0, "wbc_e4"); chk_cnt(1, "wbc_cnt");
        step();

        // Wrapped full clear start=5 end=4
        idle(); wr(0, 10, 1); wr(1, 11, 1);
        step();
        idle();
        chk_cnt(3, "pre_full_cnt");
        clr(5, 4);
        step();
        idle();
        chk_rd(0, 3, 0, "fullw_e3"); chk_rd(1, 10, 0, "fullw_e10");
        chk_rd(2, 11, 0, "fullw_e11"); chk_cnt(0, "fullw_cnt");
        step();

        // Writes during reset are ignored; forwarded reads forced to 0
        idle(); reset = 1'b1; wr(0, 7, 1); wr(1, 8, 1);
        chk_rd(0, 7, 0, "rst_rdw7");
        step();
        reset = 1'b0; idle();
        chk_rd(0, 7, 0, "mrst_e7"); chk_rd(1, 8, 0, "mrst_e8");
        chk_cnt(0, "mrst_cnt");
        step();
        step();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
